// File: rtl/spi_frame_scheduler.sv
// SPI frame scheduler: one tick -> one frame of NCH MSB-first lanes under a shared SCK/SSEL.
// Optional SPI_FRAME_PARITY_EN: each lane appends an odd-parity bit after its LSB.

module spi_frame_scheduler #(
  parameter int NCH   = 2,
  parameter int WIDTH = 32,
  parameter int DIV_W = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [DIV_W-1:0]     clkdiv,
  input  logic                 tick,
  input  logic [NCH*WIDTH-1:0] data_in,
  output logic                 SCK,
  output logic                 SSEL,
  output logic [NCH-1:0]       DATA_OUT,
  output logic                 busy,
  output logic                 frame_done,
  output logic [15:0]          overrun_cnt
);

`ifdef SPI_FRAME_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int BCW = $clog2(WIDTH + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] SCK_HI = 3'd2;
  localparam logic [2:0] SCK_LO = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;
  localparam logic [2:0] GAP    = 3'd5;

  logic [2:0]       tsync_q;
  logic             tick_evt;
  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, h_q, h_d, h_in;
  logic [BCW-1:0]   bits_q, bits_d;
  logic             half_q, half_d;
  logic             sck_q, sck_d, ssel_q, ssel_d, busy_q, busy_d, done_q, done_d;
  logic [15:0]      ovr_q, ovr_d;
  logic             load, shift, clear, expired;

  // tick may be asynchronous: two sync flops plus one for edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tsync_q <= '0;
    else          tsync_q <= {tsync_q[1:0], tick};
  end
  assign tick_evt = tsync_q[1] & ~tsync_q[2];

  assign h_in    = (clkdiv == '0) ? DIV_W'(1) : clkdiv;
  assign expired = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    bits_d  = bits_q;
    half_d  = half_q;
    sck_d   = sck_q;
    ssel_d  = ssel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    clear   = 1'b0;
    if (state_q != IDLE) cnt_d = cnt_q - DIV_W'(1);
    case (state_q)
      IDLE: if (tick_evt && en) begin
        load    = 1'b1;
        ssel_d  = 1'b0;
        busy_d  = 1'b1;
        h_d     = h_in;
        cnt_d   = h_in - DIV_W'(1);
        bits_d  = BCW'(NBITS - 1);
        state_d = SETUP;
      end
      SETUP, SCK_LO: if (expired) begin
        sck_d   = 1'b1;
        cnt_d   = h_q - DIV_W'(1);
        state_d = SCK_HI;
      end
      SCK_HI: if (expired) begin
        sck_d = 1'b0;
        cnt_d = h_q - DIV_W'(1);
        if (bits_q != '0) begin
          shift   = 1'b1;
          bits_d  = bits_q - BCW'(1);
          state_d = SCK_LO;
        end else begin
          half_d  = 1'b0;
          state_d = HOLD;
        end
      end
      // HOLD spans two half-periods: a trailing SCK-low phase on the last bit, then select hold
      HOLD: if (expired) begin
        cnt_d = h_q - DIV_W'(1);
        if (!half_q) begin
          half_d = 1'b1;
        end else begin
          half_d  = 1'b0;
          ssel_d  = 1'b1;
          clear   = 1'b1;
          state_d = GAP;
        end
      end
      GAP: if (expired) begin
        cnt_d = h_q - DIV_W'(1);
        if (!half_q) begin
          half_d = 1'b1;
        end else begin
          half_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ticks outside IDLE (including the cycle IDLE is re-entered) are dropped and counted
  always_comb begin
    ovr_d = ovr_q;
    if (tick_evt && (state_q != IDLE) && (ovr_q != 16'hFFFF)) ovr_d = ovr_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      h_q     <= '0;
      bits_q  <= '0;
      half_q  <= 1'b0;
      sck_q   <= 1'b0;
      ssel_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      bits_q  <= bits_d;
      half_q  <= half_d;
      sck_q   <= sck_d;
      ssel_q  <= ssel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    logic [WIDTH-1:0] word;
    logic [NBITS-1:0] init;
    logic [NBITS-1:0] sh_q;
    assign word = data_in[k*WIDTH +: WIDTH];
`ifdef SPI_FRAME_PARITY_EN
    assign init = {word, ~^word};
`else
    assign init = word;
`endif
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   sh_q <= '0;
      else if (load)  sh_q <= init;
      else if (clear) sh_q <= '0;
      else if (shift) sh_q <= {sh_q[NBITS-2:0], 1'b0};
    end
    assign DATA_OUT[k] = sh_q[NBITS-1];
  end

  assign SCK         = sck_q;
  assign SSEL        = ssel_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign overrun_cnt = ovr_q;

endmodule
